// File: rtl/neural_pkg.sv
// Shared types and default constants for the layer sequencer and its MAC unit.
package neural_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        MAC,
        WRITE,
        DONE
    } state_t;

    localparam int DEF_ADDR_W = 8;
    localparam logic [DEF_ADDR_W-1:0] DEF_END_CODE = '1;
    localparam int DEF_BANK0_BASE = 0;
    localparam int DEF_BANK1_BASE = 20;
    localparam int DEF_MAX_LAYER_SIZE = 20;

endpackage

// File: rtl/mac_sat_unit.sv
// Signed multiply-accumulate with arithmetic shift, saturation to DATA_W and optional ReLU.
module mac_sat_unit #(
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 24,
    parameter int FRAC_BITS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              accumulate,
    input  logic              relu,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] weight,
    output logic [DATA_W-1:0] result
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] weight_ext;
    logic signed [ACC_W-1:0] product;
    logic signed [ACC_W-1:0] shifted;

    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) return SAT_MAX[DATA_W-1:0];
        if (v < SAT_MIN) return SAT_MIN[DATA_W-1:0];
        return v[DATA_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] activate(input logic en,
                                                          input logic signed [DATA_W-1:0] v);
        return (en && (v < 0)) ? '0 : v;
    endfunction

    // Operands are sign-extended first so the product wraps modulo 2^ACC_W.
    assign sample_ext = ACC_W'($signed(sample));
    assign weight_ext = ACC_W'($signed(weight));
    assign product    = sample_ext * weight_ext;
    assign shifted    = acc >>> FRAC_BITS;

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (accumulate) begin
            acc <= acc + product;
        end
    end

    assign result = activate(relu, saturate(shifted));

endmodule

// File: rtl/neural_layer_sequencer.sv
// Runs a fully-connected network layer by layer from a size program, ping-ponging between two neuron banks.
module neural_layer_sequencer
    import neural_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int ACC_W          = 24,
    parameter int FRAC_BITS      = 4,
    parameter int BANK0_BASE     = DEF_BANK0_BASE,
    parameter int BANK1_BASE     = DEF_BANK1_BASE,
    parameter int MAX_LAYER_SIZE = DEF_MAX_LAYER_SIZE,
    parameter logic [ADDR_W-1:0] END_CODE = '1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              relu_en,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic [ADDR_W-1:0] instr_data,
    output logic [ADDR_W-1:0] weight_addr,
    input  logic [DATA_W-1:0] weight_data,
    output logic [ADDR_W-1:0] neuro_rd_addr,
    input  logic [DATA_W-1:0] neuro_rd_data,
    output logic [ADDR_W-1:0] neuro_wr_addr,
    output logic [DATA_W-1:0] neuro_wr_data,
    output logic              neuro_we,
    output logic [ADDR_W-1:0] result_base_address,
    output logic [ADDR_W-1:0] result_word_count,
    output logic [ADDR_W-1:0] layers_done
);

    localparam logic [ADDR_W-1:0] BANK0    = ADDR_W'(BANK0_BASE);
    localparam logic [ADDR_W-1:0] BANK1    = ADDR_W'(BANK1_BASE);
    localparam logic [ADDR_W-1:0] MAX_SIZE = ADDR_W'(MAX_LAYER_SIZE);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    state_t state, next_state;

    logic [ADDR_W-1:0] ip;
    logic [ADDR_W-1:0] prev_size;
    logic [ADDR_W-1:0] cur_size;
    logic [ADDR_W-1:0] i_cnt;
    logic [ADDR_W-1:0] j_cnt;
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W-1:0] layer_cnt;
    logic [ADDR_W-1:0] res_base;
    logic [ADDR_W-1:0] res_count;
    logic              bank_sel;
    logic              relu_lat;
    logic              err;

    logic [ADDR_W-1:0] rd_base;
    logic [ADDR_W-1:0] wr_base;
    logic              size_legal;
    logic              is_end;
    logic              last_i;
    logic              last_j;
    logic              mac_clear;
    logic              mac_acc;
    logic [DATA_W-1:0] act_out;

    // bank_sel==0 means the current layer reads bank 0 and writes bank 1.
    assign rd_base    = bank_sel ? BANK1 : BANK0;
    assign wr_base    = bank_sel ? BANK0 : BANK1;
    assign size_legal = (instr_data != '0) && (instr_data <= MAX_SIZE);
    assign is_end     = (instr_data == END_CODE);
    assign last_i     = (i_cnt == prev_size - ONE);
    assign last_j     = (j_cnt == cur_size - ONE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        mac_clear  = 1'b0;
        mac_acc    = 1'b0;
        case (state)
            IDLE:  if (start) next_state = LOAD;
            LOAD:  next_state = size_legal ? FETCH : DONE;
            FETCH: begin
                mac_clear  = 1'b1;
                next_state = (is_end || !size_legal) ? DONE : MAC;
            end
            MAC: begin
                mac_acc = 1'b1;
                if (last_i) next_state = WRITE;
            end
            WRITE: begin
                mac_clear  = 1'b1;
                next_state = last_j ? FETCH : MAC;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ip        <= '0;
            prev_size <= '0;
            cur_size  <= '0;
            i_cnt     <= '0;
            j_cnt     <= '0;
            wptr      <= '0;
            layer_cnt <= '0;
            res_base  <= BANK0;
            res_count <= '0;
            bank_sel  <= 1'b0;
            relu_lat  <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    ip        <= '0;
                    wptr      <= '0;
                    layer_cnt <= '0;
                    bank_sel  <= 1'b0;
                    relu_lat  <= relu_en;
                    err       <= 1'b0;
                end
                LOAD: begin
                    prev_size <= instr_data;
                    if (size_legal) ip <= ONE;
                    else            err <= 1'b1;
                end
                FETCH: begin
                    i_cnt <= '0;
                    j_cnt <= '0;
                    if (!is_end) begin
                        if (size_legal) cur_size <= instr_data;
                        else            err      <= 1'b1;
                    end
                end
                MAC: begin
                    i_cnt <= i_cnt + ONE;
                    wptr  <= wptr + ONE;
                end
                WRITE: begin
                    i_cnt <= '0;
                    j_cnt <= j_cnt + ONE;
                    if (last_j) begin
                        prev_size <= cur_size;
                        ip        <= ip + ONE;
                        bank_sel  <= ~bank_sel;
                        layer_cnt <= layer_cnt + ONE;
                        res_base  <= wr_base;
                        res_count <= cur_size;
                    end
                end
                default: ;
            endcase
        end
    end

    mac_sat_unit #(
        .DATA_W   (DATA_W),
        .ACC_W    (ACC_W),
        .FRAC_BITS(FRAC_BITS)
    ) u_mac (
        .clk       (clk),
        .reset     (reset),
        .clear     (mac_clear),
        .accumulate(mac_acc),
        .relu      (relu_lat),
        .sample    (neuro_rd_data),
        .weight    (weight_data),
        .result    (act_out)
    );

    assign busy                = (state != IDLE);
    assign done                = (state == DONE);
    assign neuro_we            = (state == WRITE);
    assign error               = err;
    assign instr_addr          = ip;
    assign weight_addr         = wptr;
    assign neuro_rd_addr       = (state == MAC) ? rd_base + i_cnt : '0;
    assign neuro_wr_addr       = (state == WRITE) ? wr_base + j_cnt : '0;
    assign neuro_wr_data       = (state == WRITE) ? act_out : '0;
    assign result_base_address = res_base;
    assign result_word_count   = res_count;
    assign layers_done         = layer_cnt;

endmodule

// File: tb/tb_neural_layer_sequencer.sv
// Directed bench: two sequencer instances (FRAC_BITS 4 and 0) share program/weight memories, each with its own neuron RAM.
module tb_neural_layer_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic relu_en = 1'b0;

    always #5 clk = ~clk;

    logic [7:0] imem[256];
    logic [7:0] wmem[256];
    logic [7:0] init_mem[256];
    logic [7:0] nmem_a[256];
    logic [7:0] nmem_b[256];
    logic       load_req = 1'b0;
    int         we_cnt_a = 0;
    int         we_cnt_b = 0;

    logic       busy_a, done_a, error_a, we_a;
    logic [7:0] instr_addr_a, instr_data_a, weight_addr_a, weight_data_a;
    logic [7:0] rd_addr_a, rd_data_a, wr_addr_a, wr_data_a, res_base_a, res_cnt_a, layers_a;
    logic       busy_b, done_b, error_b, we_b;
    logic [7:0] instr_addr_b, instr_data_b, weight_addr_b, weight_data_b;
    logic [7:0] rd_addr_b, rd_data_b, wr_addr_b, wr_data_b, res_base_b, res_cnt_b, layers_b;

    assign instr_data_a  = imem[instr_addr_a];
    assign weight_data_a = wmem[weight_addr_a];
    assign rd_data_a     = nmem_a[rd_addr_a];
    assign instr_data_b  = imem[instr_addr_b];
    assign weight_data_b = wmem[weight_addr_b];
    assign rd_data_b     = nmem_b[rd_addr_b];

    neural_layer_sequencer #(.DATA_W(8), .ADDR_W(8), .ACC_W(24), .FRAC_BITS(4)) dut_a (
        .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
        .busy(busy_a), .done(done_a), .error(error_a),
        .instr_addr(instr_addr_a), .instr_data(instr_data_a),
        .weight_addr(weight_addr_a), .weight_data(weight_data_a),
        .neuro_rd_addr(rd_addr_a), .neuro_rd_data(rd_data_a),
        .neuro_wr_addr(wr_addr_a), .neuro_wr_data(wr_data_a), .neuro_we(we_a),
        .result_base_address(res_base_a), .result_word_count(res_cnt_a), .layers_done(layers_a)
    );

    neural_layer_sequencer #(.DATA_W(8), .ADDR_W(8), .ACC_W(24), .FRAC_BITS(0)) dut_b (
        .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
        .busy(busy_b), .done(done_b), .error(error_b),
        .instr_addr(instr_addr_b), .instr_data(instr_data_b),
        .weight_addr(weight_addr_b), .weight_data(weight_data_b),
        .neuro_rd_addr(rd_addr_b), .neuro_rd_data(rd_data_b),
        .neuro_wr_addr(wr_addr_b), .neuro_wr_data(wr_data_b), .neuro_we(we_b),
        .result_base_address(res_base_b), .result_word_count(res_cnt_b), .layers_done(layers_b)
    );

    // Neuron RAM: preload on request, otherwise capture DUT writes mid-cycle.
    always @(negedge clk) begin
        if (load_req) begin
            for (int k = 0; k < 256; k++) begin
                nmem_a[k] <= init_mem[k];
                nmem_b[k] <= init_mem[k];
            end
        end else begin
            if (we_a) begin
                nmem_a[wr_addr_a] <= wr_data_a;
                we_cnt_a <= we_cnt_a + 1;
            end
            if (we_b) begin
                nmem_b[wr_addr_b] <= wr_data_b;
                we_cnt_b <= we_cnt_b + 1;
            end
        end
    end

    typedef struct {
        int prog[5];
        int inp[3];
        int w[12];
        bit relu;
        int nexp;
        int expa[3];
        int expb[3];
        int ebase;
        int elayers;
        int ecycle;
        bit eerr;
        int ewrites;
    } vec_t;

    vec_t vecs[10];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic clear_mems();
        for (int k = 0; k < 256; k++) begin
            imem[k]     = 8'hFF;
            wmem[k]     = 8'h00;
            init_mem[k] = 8'h00;
        end
    endtask

    task automatic apply_load();
        @(posedge clk);
        load_req = 1'b1;
        @(negedge clk);
        #1;
        load_req = 1'b0;
    endtask

    // Pulses start (with relu level) and returns the cycle in which done is seen; start edge is cycle 0.
    task automatic start_and_wait(input bit relu, input int busy_pulse_at, output int cyc);
        @(negedge clk);
        start   = 1'b1;
        relu_en = relu;
        @(negedge clk);
        start   = 1'b0;
        relu_en = 1'b0;
        cyc     = 1;
        while (!done_a && cyc < 400) begin
            if (cyc == busy_pulse_at) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   cyc, wa0, wb0;
        string p;
        v = vecs[idx];
        p = $sformatf("v%0d", idx);
        clear_mems();
        for (int k = 0; k < 5; k++) imem[k] = 8'(v.prog[k]);
        for (int k = 0; k < 3; k++) init_mem[k] = 8'(v.inp[k]);
        for (int k = 0; k < 12; k++) wmem[k] = 8'(v.w[k]);
        apply_load();
        wa0 = we_cnt_a;
        wb0 = we_cnt_b;
        start_and_wait(v.relu, -1, cyc);
        check({p, "_done_cycle"}, cyc, v.ecycle);
        check({p, "_busy_in_done"}, int'(busy_a), 1);
        check({p, "_done_b"}, int'(done_b), 1);
        check({p, "_error"}, int'(error_a), int'(v.eerr));
        check({p, "_layers_done"}, int'(layers_a), v.elayers);
        if (v.nexp > 0) begin
            check({p, "_result_base"}, int'(res_base_a), v.ebase);
            check({p, "_word_count"}, int'(res_cnt_a), v.nexp);
        end
        @(negedge clk);
        check({p, "_done_pulse_end"}, int'(done_a), 0);
        check({p, "_busy_after"}, int'(busy_a), 0);
        check({p, "_writes"}, we_cnt_a - wa0, v.ewrites);
        check({p, "_writes_b"}, we_cnt_b - wb0, v.ewrites);
        for (int k = 0; k < v.nexp; k++) begin
            check($sformatf("%s_out_a%0d", p, k), int'($signed(nmem_a[v.ebase + k])), v.expa[k]);
            check($sformatf("%s_out_b%0d", p, k), int'($signed(nmem_b[v.ebase + k])), v.expb[k]);
        end
    endtask

    initial begin
        int cyc, wa0;
        int seen_busy;

        vecs[0] = '{'{2, 2, 255, 255, 255}, '{3, 5, 0}, '{16, 0, 0, 16, 0, 0, 0, 0, 0, 0, 0, 0}, 1'b0,
                    2, '{3, 5, 0}, '{48, 80, 0}, 20, 1, 10, 1'b0, 2};
        vecs[1] = '{'{2, 2, 255, 255, 255}, '{3, 5, 0}, '{-16, 0, 0, 16, 0, 0, 0, 0, 0, 0, 0, 0}, 1'b1,
                    2, '{0, 5, 0}, '{0, 80, 0}, 20, 1, 10, 1'b0, 2};
        vecs[2] = '{'{2, 2, 255, 255, 255}, '{3, 5, 0}, '{-16, 0, 0, 16, 0, 0, 0, 0, 0, 0, 0, 0}, 1'b0,
                    2, '{-3, 5, 0}, '{-48, 80, 0}, 20, 1, 10, 1'b0, 2};
        vecs[3] = '{'{2, 1, 255, 255, 255}, '{127, 127, 0}, '{127, 127, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 1'b0,
                    1, '{127, 0, 0}, '{127, 0, 0}, 20, 1, 7, 1'b0, 1};
        vecs[4] = '{'{2, 1, 255, 255, 255}, '{127, 127, 0}, '{-128, -128, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 1'b0,
                    1, '{-128, 0, 0}, '{-128, 0, 0}, 20, 1, 7, 1'b0, 1};
        vecs[5] = '{'{2, 3, 2, 255, 255}, '{3, 5, 0}, '{16, 0, 0, 16, 16, 16, 16, 16, 0, 0, 0, 32}, 1'b0,
                    2, '{8, 16, 0}, '{127, 127, 0}, 0, 2, 22, 1'b0, 5};
        vecs[6] = '{'{2, 0, 255, 255, 255}, '{3, 5, 0}, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 1'b0,
                    0, '{0, 0, 0}, '{0, 0, 0}, 0, 0, 3, 1'b1, 0};
        vecs[7] = '{'{21, 1, 255, 255, 255}, '{3, 5, 0}, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 1'b0,
                    0, '{0, 0, 0}, '{0, 0, 0}, 0, 0, 2, 1'b1, 0};
        vecs[8] = '{'{2, 21, 255, 255, 255}, '{3, 5, 0}, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 1'b0,
                    0, '{0, 0, 0}, '{0, 0, 0}, 0, 0, 3, 1'b1, 0};
        vecs[9] = vecs[0];

        clear_mems();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy_a), 0);
        check("rst_done", int'(done_a), 0);
        check("rst_error", int'(error_a), 0);
        check("rst_we", int'(we_a), 0);
        check("rst_addrs", int'(instr_addr_a) + int'(weight_addr_a) + int'(rd_addr_a) + int'(wr_addr_a), 0);
        check("rst_result", int'(res_base_a) + int'(res_cnt_a) + int'(layers_a), 0);
        reset = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 10; n++) run_vec(n);

        // Largest legal layer: 20 inputs of 16 with unit weights -> 320.
        clear_mems();
        imem[0] = 8'd20;
        imem[1] = 8'd1;
        for (int k = 0; k < 20; k++) begin
            init_mem[k] = 8'd16;
            wmem[k]     = 8'd1;
        end
        apply_load();
        start_and_wait(1'b0, -1, cyc);
        check("max_done_cycle", cyc, 25);
        check("max_error", int'(error_a), 0);
        check("max_count", int'(res_cnt_a), 1);
        @(negedge clk);
        check("max_out_a", int'($signed(nmem_a[20])), 20);
        check("max_out_b", int'($signed(nmem_b[20])), 127);

        // A second start while busy must not disturb the run.
        clear_mems();
        imem[0] = 8'd2; imem[1] = 8'd2;
        init_mem[0] = 8'd3; init_mem[1] = 8'd5;
        wmem[0] = 8'd16; wmem[3] = 8'd16;
        apply_load();
        start_and_wait(1'b0, 4, cyc);
        check("restart_done_cycle", cyc, 10);
        @(negedge clk);
        check("restart_out0", int'($signed(nmem_a[20])), 3);
        check("restart_out1", int'($signed(nmem_a[21])), 5);
        check("restart_busy_after", int'(busy_a), 0);

        // Reset during the first MAC of a three-layer run.
        clear_mems();
        imem[0] = 8'd2; imem[1] = 8'd3; imem[2] = 8'd2;
        init_mem[0] = 8'd3; init_mem[1] = 8'd5;
        for (int k = 0; k < 12; k++) wmem[k] = 8'd16;
        apply_load();
        wa0 = we_cnt_a;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_before", int'(busy_a), 1);
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy_a), 0);
        check("abort_we", int'(we_a), 0);
        check("abort_ctrs", int'(instr_addr_a) + int'(weight_addr_a) + int'(layers_a) + int'(res_cnt_a), 0);
        check("abort_base", int'(res_base_a), 0);
        @(negedge clk);
        reset = 1'b1;
        seen_busy = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy_a) seen_busy++;
        end
        check("abort_stays_idle", seen_busy, 0);
        check("abort_no_writes", we_cnt_a - wa0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/neural_layer_sequencer.md
Name: neural_layer_sequencer

Overview:
Parametrised successor of the fixed 8-bit accelerator top. Runs a fully-connected multi-layer network from a layer-size program, starting on a start/busy/done handshake. Internal FSM, address counters and signed MAC with shift, saturation and optional ReLU; ping-pong neuron banks. All memories (instruction, weight, neuron dual-port) are external, zero-latency combinational-read.

Parameters:
DATA_W, 8, signed width of neuron values and weights
ADDR_W, 8, width of all memory addresses
ACC_W, 24, signed accumulator width (must be >= 2*DATA_W)
FRAC_BITS, 4, arithmetic right shift applied to accumulator before saturation
BANK0_BASE, 0, neuron bank 0 base address (input vector preloaded here)
BANK1_BASE, 20, neuron bank 1 base address
MAX_LAYER_SIZE, 20, largest legal layer size
END_CODE, all ones (ADDR_W bits), program terminator

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
start  in  1  begin run; sampled only in IDLE
relu_en  in  1  ReLU mode; latched when start is accepted
busy  out  1  high from start acceptance until DONE state inclusive
done  out  1  one-cycle pulse at end of run
error  out  1  sticky until next accepted start; illegal layer size
instr_addr  out  ADDR_W  instruction memory address (= ip)
instr_data  in  ADDR_W  layer size at instr_addr
weight_addr  out  ADDR_W  weight memory address
weight_data  in  DATA_W  signed weight
neuro_rd_addr  out  ADDR_W  neuron read address
neuro_rd_data  in  DATA_W  signed neuron value
neuro_wr_addr  out  ADDR_W  neuron write address
neuro_wr_data  out  DATA_W  activated result
neuro_we  out  1  neuron write enable
result_base_address  out  ADDR_W  bank base holding final layer
result_word_count  out  ADDR_W  final layer size
layers_done  out  ADDR_W  count of computed layers

Behaviour:
- Reset (reset==0 at clk edge): state IDLE; all outputs, ip, counters and accumulator 0; result_base_address = BANK0_BASE. Mid-run reset aborts immediately; no further neuro_we.
- Program: instr[0] = input size N0; instr[k] = size of layer k; END_CODE terminates. Weights contiguous from address 0, row-major: per output neuron j, weights for inputs i=0..Nprev-1; no bias.
- Layer k reads bank (k-1) mod 2, writes bank k mod 2.
- States:
  - IDLE: start=1 -> LOAD; clear error, layers_done, weight pointer; latch relu_en. start while busy ignored.
  - LOAD (1 cycle): ip=0; prev_size<=instr_data; illegal -> DONE with error; else ip<=1 -> FETCH.
  - FETCH (1 cycle): instr_data==END_CODE -> DONE. Illegal -> DONE with error. Else cur_size<=instr_data, i=j=0, acc=0 -> MAC.
  - MAC (prev_size cycles): acc += rd_data*weight_data (full-width signed product, sign-extended, wraps at ACC_W); neuro_rd_addr = rd_base+i; weight pointer++ each cycle. Last i -> WRITE.
  - WRITE (1 cycle): neuro_we=1, wr_addr = wr_base+j, wr_data = act(sat(acc >>> FRAC_BITS)); acc<=0; j++. j==cur_size-1 -> prev_size<=cur_size, ip++, toggle banks, layers_done++, result_base_address<=wr_base, result_word_count<=cur_size, -> FETCH; else -> MAC.
  - DONE (1 cycle): done=1, busy=1 -> IDLE.
- Illegal size: 0 or > MAX_LAYER_SIZE (END_CODE only legal in FETCH).
- sat: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. act: relu latched -> negatives become 0.
- Cycles per layer: 1 + cur*(prev+1). done high in cycle L+3+sum(cur*(prev+1)) after start edge, L = layer count.
- neuro_we low outside WRITE; writes never target the bank being read.

Decomposition:
- Package neural_pkg: state enum (IDLE, LOAD, FETCH, MAC, WRITE, DONE), END_CODE, bank-base constants.
- Sub-module mac_sat_unit: accumulator, shift, saturation, ReLU; clear/accumulate controls.

Test Plan:
- FRAC_BITS=4, program [2,2,END], input [3,5], weights [16,0,0,16] -> bank1 addr 20,21 = 3,5; done in cycle 10; result_base_address=20, word_count=2, layers_done=1.
- Same, weights [-16,0,0,16], relu_en=1 -> [0,5]; relu_en=0 -> [-3,5].
- FRAC_BITS=0, [2,1,END], input [127,127], weights [127,127] -> 127; weights [-128,-128] -> -128.
- Three layers [2,3,2,END] -> final data in bank0, result_base_address=0, layers_done=2, exact done cycle per formula.
- Program [2,0,END] -> error=1, done pulse, no neuro_we; next start clears error.
- Reset low mid-MAC -> IDLE next cycle, busy/neuro_we 0; start pulse while busy ignored.
